async_elastic_buffer: RTL and testbench

- Parametrised successor to the chain of single-token "reg" async operators used for path balancing in generated arf dataflow graphs.
- One block replaces N chained reg stages. It holds up to `depth` tokens in a circular buffer and fans out to `output_size` consumers.
- Uses the codebase's pull handshake on both sides:
  - Upstream side: the block raises `req_l`, and the producer answers with a one-cycle `ack_l` plus data.
  - Downstream side: all consumers raise `req_r`, and the block answers with a one-cycle `ack_r` plus `dout`.

---
 rtl/async_pkg.sv | 26 ++
 rtl/async_buf_mem.sv | 41 ++++
 rtl/async_elastic_buffer.sv | 122 ++++++++++++
 tb/tb_async_elastic_buffer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_pkg.sv
// -----------------------------------------------------------------------------
// async_pkg
// Shared definitions for the async dataflow operators emitted by the arf
// graph generator.
//   DATA_WIDTH        default token width
//   OP_*              operator names the generator uses when instantiating
//   OCC_W(depth)      width of an occupancy count able to hold 0..depth
//   PTR_W(depth)      width of a buffer index 0..depth-1 (never below 1)
// -----------------------------------------------------------------------------
package async_pkg;

  localparam int DATA_WIDTH = 32;

  localparam string OP_REG            = "reg";
  localparam string OP_ELASTIC_BUFFER = "async_elastic_buffer";

  function automatic int OCC_W(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A single-entry buffer still needs a one-bit index to have a legal vector.
  function automatic int PTR_W(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/async_buf_mem.sv
// -----------------------------------------------------------------------------
// async_buf_mem
// Token storage for async_elastic_buffer: depth x data_width registers with
// one synchronous write port and one combinational read port.
//   clk      clock
//   wr_en    write strobe, wr_data stored at wr_ptr on the rising edge
//   wr_ptr   write index (0..depth-1)
//   wr_data  token to store
//   rd_ptr   read index (0..depth-1)
//   rd_data  token currently stored at rd_ptr
// -----------------------------------------------------------------------------
module async_buf_mem
  import async_pkg::*;
#(
  parameter  int data_width = DATA_WIDTH,
  parameter  int depth      = 4,
  localparam int ptr_w      = PTR_W(depth)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ptr_w-1:0]      wr_ptr,
  input  logic [data_width-1:0] wr_data,
  input  logic [ptr_w-1:0]      rd_ptr,
  output logic [data_width-1:0] rd_data
);

  logic [data_width-1:0] mem [depth];

  // NOTE: storage has no reset; occupancy guarantees an entry is written
  // before it is ever read, so clearing it would only cost reset fan-out.
  // NOTE: registers are always written with <= so every process sees the
  // pre-edge value, independent of evaluation order.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/async_elastic_buffer.sv
// -----------------------------------------------------------------------------
// async_elastic_buffer
// Circular token buffer replacing a chain of single-token "reg" operators.
// Both sides use the pull handshake: the buffer requests a token with req_l
// and the producer answers with a one-cycle ack_l plus din; consumers request
// with req_r (all bits high) and the buffer answers with a one-cycle ack_r
// plus dout.
//   clk        clock
//   rst        asynchronous reset, active low
//   req_l      request to the upstream producer (registered)
//   ack_l      upstream data-valid pulse, din sampled with it
//   din        upstream token
//   req_r      one request bit per consumer
//   ack_r      pop pulse to all consumers
//   dout       token delivered with ack_r, held between pops
//   occupancy  number of stored tokens
//   err        (only with ASYNC_ELASTIC_BUFFER_ERR_EN) sticky protocol error:
//              ack_l while full or while req_l was low
// -----------------------------------------------------------------------------
module async_elastic_buffer
  import async_pkg::*;
#(
  parameter  int data_width  = DATA_WIDTH,
  parameter  int depth       = 4,
  parameter  int output_size = 1,
  localparam int occ_w       = OCC_W(depth),
  localparam int ptr_w       = PTR_W(depth)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   req_l,
  input  logic                   ack_l,
  input  logic [data_width-1:0]  din,
  input  logic [output_size-1:0] req_r,
  output logic                   ack_r,
  output logic [data_width-1:0]  dout,
  output logic [occ_w-1:0]       occupancy
`ifdef ASYNC_ELASTIC_BUFFER_ERR_EN
  ,
  output logic                   err
`endif
);

  localparam logic [occ_w-1:0] FULL_OCC = occ_w'(depth);
  localparam logic [ptr_w-1:0] LAST_PTR = ptr_w'(depth - 1);

  logic [ptr_w-1:0]      wr_ptr;
  logic [ptr_w-1:0]      rd_ptr;
  logic [ptr_w-1:0]      wr_ptr_next;
  logic [ptr_w-1:0]      rd_ptr_next;
  logic [occ_w-1:0]      occ_next;
  logic [data_width-1:0] rd_data;
  logic                  full;
  logic                  push;
  logic                  pop;

  // Pointers wrap at depth-1 explicitly so any depth works, not just 2^n.
  function automatic logic [ptr_w-1:0] wrap_inc(input logic [ptr_w-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ptr_w'(1);
  endfunction

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    full        = (occupancy == FULL_OCC);
    // An ack while full breaks the protocol; the token is simply dropped.
    push        = ack_l && !full;
    // Gating on the current ack_r covers the cycle in which consumers still
    // hold req_r after an ack, so one request never pops twice.
    pop         = (occupancy != '0) && (&req_r) && !ack_r;
    wr_ptr_next = push ? wrap_inc(wr_ptr) : wr_ptr;
    rd_ptr_next = pop  ? wrap_inc(rd_ptr) : rd_ptr;
    occ_next    = occupancy + occ_w'(push) - occ_w'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      req_l     <= 1'b0;
      ack_r     <= 1'b0;
      dout      <= '0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      occupancy <= occ_next;
      // Dropping req_l for the cycle after each ack keeps at most one
      // upstream request outstanding; it also stays low while full.
      req_l     <= !ack_l && (occ_next != FULL_OCC);
      ack_r     <= pop;
      if (pop) begin
        dout <= rd_data;
      end
    end
  end

  // The read is taken from the registered array, so a token written on edge
  // k is first visible to a pop on edge k+1: no same-cycle bypass.
  async_buf_mem #(
    .data_width (data_width),
    .depth      (depth)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (wr_ptr),
    .wr_data (din),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

`ifdef ASYNC_ELASTIC_BUFFER_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (ack_l && (full || !req_l)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_async_elastic_buffer.sv
// -----------------------------------------------------------------------------
// tb_async_elastic_buffer
// Bench for async_elastic_buffer. Instance a: depth 4, one consumer, 32-bit
// tokens, tracked every cycle by a queue-based reference model. Instance b:
// depth 3, three consumers, 8-bit tokens, driven from a table of vectors.
// Define ASYNC_ELASTIC_BUFFER_ERR_EN to also check the err output.
// -----------------------------------------------------------------------------
module tb_async_elastic_buffer;

  logic clk;
  logic rst;

  // Instance a
  logic        a_req_l;
  logic        a_ack_l;
  logic [31:0] a_din;
  logic [0:0]  a_req_r;
  logic        a_ack_r;
  logic [31:0] a_dout;
  logic [2:0]  a_occ;
  logic        a_err;

  // Instance b
  logic       b_req_l;
  logic       b_ack_l;
  logic [7:0] b_din;
  logic [2:0] b_req_r;
  logic       b_ack_r;
  logic [7:0] b_dout;
  logic [1:0] b_occ;
  logic       b_err;

  int n_checks = 0;
  int n_pass   = 0;

  async_elastic_buffer #(
    .data_width  (32),
    .depth       (4),
    .output_size (1)
  ) u_a (
    .clk       (clk),
    .rst       (rst),
    .req_l     (a_req_l),
    .ack_l     (a_ack_l),
    .din       (a_din),
    .req_r     (a_req_r),
    .ack_r     (a_ack_r),
    .dout      (a_dout),
    .occupancy (a_occ)
`ifdef ASYNC_ELASTIC_BUFFER_ERR_EN
    ,
    .err       (a_err)
`endif
  );

  async_elastic_buffer #(
    .data_width  (8),
    .depth       (3),
    .output_size (3)
  ) u_b (
    .clk       (clk),
    .rst       (rst),
    .req_l     (b_req_l),
    .ack_l     (b_ack_l),
    .din       (b_din),
    .req_r     (b_req_r),
    .ack_r     (b_ack_r),
    .dout      (b_dout),
    .occupancy (b_occ)
`ifdef ASYNC_ELASTIC_BUFFER_ERR_EN
    ,
    .err       (b_err)
`endif
  );

`ifndef ASYNC_ELASTIC_BUFFER_ERR_EN
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model for instance a: the buffer contents are a queue; a pop
  // takes the head when consumers ask and no ack went out last cycle, an
  // accepted ack appends to the tail, and the producer is asked for more
  // whenever there is room and no ack arrived this cycle.
  // ---------------------------------------------------------------------------
  localparam int A_DEPTH = 4;
  logic [31:0] m_q[$];
  logic        m_req_l;
  logic        m_ack_r;
  logic [31:0] m_dout;
  logic        m_err;
  logic        a_chk_en = 1'b0;
  logic        a_prev_ack = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_req_l = 1'b0;
      m_ack_r = 1'b0;
      m_dout  = '0;
      m_err   = 1'b0;
    end else begin
      bit was_full;
      bit take;
      was_full = (m_q.size() == A_DEPTH);
      take     = (m_q.size() > 0) && (&a_req_r) && !m_ack_r;
      if (a_ack_l && (was_full || !m_req_l)) m_err = 1'b1;
      if (take) m_dout = m_q.pop_front();
      m_ack_r = take;
      if (a_ack_l && !was_full) m_q.push_back(a_din);
      m_req_l = !a_ack_l && (m_q.size() < A_DEPTH);
    end
  end

  always @(negedge clk) begin
    if (a_chk_en) begin
      check("a_req_l", a_req_l, m_req_l);
      check("a_ack_r", a_ack_r, m_ack_r);
      check("a_dout", a_dout, m_dout);
      check("a_occupancy", a_occ, m_q.size());
`ifdef ASYNC_ELASTIC_BUFFER_ERR_EN
      check("a_err", a_err, m_err);
`endif
      check("a_ack_r_back_to_back", a_prev_ack && a_ack_r, 1'b0);
      a_prev_ack = a_ack_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table for instance b (depth 3, three consumers). Each row is one
  // clock edge: inputs driven before it, outputs expected after it.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       ack_l;
    logic [7:0] din;
    logic [2:0] req_r;
    logic       exp_req_l;
    logic       exp_ack_r;
    logic [7:0] exp_dout;
    logic [1:0] exp_occ;
  } vec_t;

  localparam int N_VEC = 23;
  vec_t vecs[N_VEC];

  initial begin
    logic [31:0] got[4];
    logic [31:0] sb[$];
    int          n_got;
    int          val;
    int          sent;
    int          recv;
    int          cyc;
    bit          seen;

    //                ack  din    req_r   req_l ack_r dout   occ
    vecs[0]  = '{1'b0, 8'd0,  3'b011, 1'b1, 1'b0, 8'd0,  2'd0}; // empty, partial req
    vecs[1]  = '{1'b1, 8'd10, 3'b011, 1'b0, 1'b0, 8'd0,  2'd1};
    vecs[2]  = '{1'b0, 8'd0,  3'b011, 1'b1, 1'b0, 8'd0,  2'd1}; // partial: no pop
    vecs[3]  = '{1'b1, 8'd11, 3'b011, 1'b0, 1'b0, 8'd0,  2'd2};
    vecs[4]  = '{1'b0, 8'd0,  3'b011, 1'b1, 1'b0, 8'd0,  2'd2};
    vecs[5]  = '{1'b1, 8'd12, 3'b011, 1'b0, 1'b0, 8'd0,  2'd3};
    vecs[6]  = '{1'b0, 8'd0,  3'b011, 1'b0, 1'b0, 8'd0,  2'd3}; // full: req_l low
    vecs[7]  = '{1'b0, 8'd0,  3'b111, 1'b1, 1'b1, 8'd10, 2'd2}; // all requests: pop
    vecs[8]  = '{1'b0, 8'd0,  3'b111, 1'b1, 1'b0, 8'd10, 2'd2}; // no back-to-back
    vecs[9]  = '{1'b0, 8'd0,  3'b111, 1'b1, 1'b1, 8'd11, 2'd1};
    vecs[10] = '{1'b1, 8'd13, 3'b011, 1'b0, 1'b0, 8'd11, 2'd2}; // write ptr wraps
    vecs[11] = '{1'b0, 8'd0,  3'b011, 1'b1, 1'b0, 8'd11, 2'd2};
    vecs[12] = '{1'b1, 8'd14, 3'b011, 1'b0, 1'b0, 8'd11, 2'd3};
    vecs[13] = '{1'b0, 8'd0,  3'b111, 1'b1, 1'b1, 8'd12, 2'd2}; // read ptr wraps
    vecs[14] = '{1'b0, 8'd0,  3'b111, 1'b1, 1'b0, 8'd12, 2'd2};
    vecs[15] = '{1'b0, 8'd0,  3'b111, 1'b1, 1'b1, 8'd13, 2'd1};
    vecs[16] = '{1'b1, 8'd15, 3'b111, 1'b0, 1'b0, 8'd13, 2'd2};
    vecs[17] = '{1'b0, 8'd0,  3'b111, 1'b1, 1'b1, 8'd14, 2'd1};
    vecs[18] = '{1'b0, 8'd0,  3'b111, 1'b1, 1'b0, 8'd14, 2'd1};
    vecs[19] = '{1'b1, 8'd16, 3'b111, 1'b0, 1'b1, 8'd15, 2'd1}; // push + pop
    vecs[20] = '{1'b0, 8'd0,  3'b111, 1'b1, 1'b0, 8'd15, 2'd1};
    vecs[21] = '{1'b0, 8'd0,  3'b111, 1'b1, 1'b1, 8'd16, 2'd0};
    vecs[22] = '{1'b0, 8'd0,  3'b111, 1'b1, 1'b0, 8'd16, 2'd0}; // empty: no pop

    rst     = 1'b1;
    a_ack_l = 1'b0;
    a_din   = '0;
    a_req_r = 1'b0;
    b_ack_l = 1'b0;
    b_din   = '0;
    b_req_r = '0;

    // ---- reset state ----
    #2 rst = 1'b0;
    #1;
    check("rst_a_req_l", a_req_l, 1'b0);
    check("rst_a_ack_r", a_ack_r, 1'b0);
    check("rst_a_dout", a_dout, 32'd0);
    check("rst_a_occ", a_occ, 3'd0);
    check("rst_b_req_l", b_req_l, 1'b0);
    check("rst_b_occ", b_occ, 2'd0);
    repeat (2) @(negedge clk);
    a_chk_en = 1'b1;

    // ---- idle producer, consumer requesting ----
    a_req_r = 1'b1;
    rst     = 1'b1;
    @(negedge clk);
    check("idle_req_l_rises", a_req_l, 1'b1);
    repeat (3) @(negedge clk);
    check("idle_ack_r", a_ack_r, 1'b0);
    check("idle_occ", a_occ, 3'd0);

    // ---- fill to full with the consumer silent ----
    a_req_r = 1'b0;
    val     = 0;
    seen    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (a_occ == 3'd4) begin
        seen = 1'b1;
        break;
      end
      if (a_req_l) begin
        a_ack_l = 1'b1;
        a_din   = val;
        val++;
      end else begin
        a_ack_l = 1'b0;
      end
      @(negedge clk);
    end
    a_ack_l = 1'b0;
    check("fill_reached_full", seen, 1'b1);
    check("fill_occ", a_occ, 3'd4);
    @(negedge clk);
    check("full_req_l_low", a_req_l, 1'b0);

    // Unsolicited ack while full: token 99 must vanish.
    a_ack_l = 1'b1;
    a_din   = 32'd99;
    @(negedge clk);
    a_ack_l = 1'b0;
    check("overflow_occ", a_occ, 3'd4);
`ifdef ASYNC_ELASTIC_BUFFER_ERR_EN
    check("overflow_err", a_err, 1'b1);
`endif

    // Release the consumer: expect 0,1,2,3.
    a_req_r = 1'b1;
    n_got   = 0;
    for (int i = 0; i < 40 && n_got < 4; i++) begin
      @(negedge clk);
      if (a_ack_r) begin
        got[n_got] = a_dout;
        n_got++;
      end
    end
    check("drain_count", n_got, 4);
    for (int i = 0; i < 4; i++) check($sformatf("drain_tok%0d", i), got[i], i);

    // ---- random streaming, 5000 tokens ----
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 5000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (a_ack_r) begin
        check("stream_sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) check("stream_dout", a_dout, sb.pop_front());
        recv++;
      end
      if (a_req_l && sent < 5000 && $urandom_range(3) != 0) begin
        a_ack_l = 1'b1;
        a_din   = $urandom;
        sb.push_back(a_din);
        sent++;
      end else begin
        a_ack_l = 1'b0;
      end
      a_req_r = ($urandom_range(3) != 0);
    end
    a_ack_l = 1'b0;
    check("stream_recv", recv, 5000);

    // ---- asynchronous reset with two tokens inside ----
    a_req_r = 1'b0;
    val     = 200;
    seen    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_occ == 3'd2) begin
        seen = 1'b1;
        break;
      end
      if (a_req_l) begin
        a_ack_l = 1'b1;
        a_din   = val;
        val++;
      end else begin
        a_ack_l = 1'b0;
      end
    end
    a_ack_l = 1'b0;
    check("mid_occ_two", seen, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_occ", a_occ, 3'd0);
    check("mid_rst_req_l", a_req_l, 1'b0);
    check("mid_rst_ack_r", a_ack_r, 1'b0);
    check("mid_rst_dout", a_dout, 32'd0);
`ifdef ASYNC_ELASTIC_BUFFER_ERR_EN
    check("mid_rst_err", a_err, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_req_l", a_req_l, 1'b1);
    a_req_r = 1'b1;
    val     = 500;
    seen    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (a_ack_r) begin
        seen = 1'b1;
        check("post_rst_first_tok", a_dout, 32'd500);
        break;
      end
      if (a_req_l && val < 502) begin
        a_ack_l = 1'b1;
        a_din   = val;
        val++;
      end else begin
        a_ack_l = 1'b0;
      end
      @(negedge clk);
    end
    a_ack_l = 1'b0;
    check("post_rst_delivered", seen, 1'b1);

    // ---- table-driven vectors on instance b ----
    @(negedge clk);
    for (int i = 0; i < N_VEC; i++) begin
      b_ack_l = vecs[i].ack_l;
      b_din   = vecs[i].din;
      b_req_r = vecs[i].req_r;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_req_l", i), b_req_l, vecs[i].exp_req_l);
      check($sformatf("vec%0d_ack_r", i), b_ack_r, vecs[i].exp_ack_r);
      check($sformatf("vec%0d_dout", i), b_dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_occ", i), b_occ, vecs[i].exp_occ);
    end
    b_ack_l = 1'b0;
    b_req_r = '0;
`ifdef ASYNC_ELASTIC_BUFFER_ERR_EN
    check("b_err_clean", b_err, 1'b0);
`endif

    a_chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
